// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for IF/ID and ID/EX: load-use bubble, branch flush,
// multi-cycle mul/div freeze, and a saturating stall-cycle counter.
module hazard_stall_ctrl #(
   parameter int unsigned REG_ADDR_W    = 6,
   parameter int unsigned MULDIV_CYCLES = 8,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
   input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
   input  logic                  id_uses_rt_i,
   input  logic                  id_muldiv_i,
   input  logic                  branch_taken_i,
   input  logic                  ex_mem_read_i,
   input  logic [REG_ADDR_W-1:0] ex_rt_addr_i,
   output logic                  pc_write_o,
   output logic                  if_id_write_o,
   output logic                  if_id_flush_o,
   output logic                  id_ex_bubble_o,
   output logic                  id_ex_hold_o,
   output logic                  ex_busy_o,
   output logic                  md_done_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   localparam int unsigned MD_W = 8;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [MD_W-1:0] md_cnt, md_cnt_nxt;
   logic            lu;

   // Load in EX writes a register the instruction in ID is about to read
   assign lu = ex_mem_read_i && (ex_rt_addr_i != '0) &&
               ((ex_rt_addr_i == id_rs_addr_i) ||
                (id_uses_rt_i && (ex_rt_addr_i == id_rt_addr_i)));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // Next state and control outputs; outputs are combinational by design
   always_comb begin
      state_nxt      = state;
      md_cnt_nxt     = md_cnt;
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      id_ex_hold_o   = 1'b0;
      ex_busy_o      = 1'b0;
      md_done_o      = 1'b0;

      if (!rst_n_i) begin
         id_ex_bubble_o = 1'b1;
      end else begin
         unique case (state)
            RUN: begin
               pc_write_o    = 1'b1;
               if_id_write_o = 1'b1;
               if (lu) begin
                  pc_write_o     = 1'b0;
                  if_id_write_o  = 1'b0;
                  id_ex_bubble_o = 1'b1;
               end else if (branch_taken_i) begin
                  if_id_flush_o = 1'b1;
               end else if (id_muldiv_i) begin
                  state_nxt  = MD_BUSY;
                  md_cnt_nxt = MD_W'(MULDIV_CYCLES - 1);
               end
            end
            MD_BUSY: begin
               id_ex_hold_o = 1'b1;
               ex_busy_o    = 1'b1;
               if (md_cnt == '0) begin
                  md_done_o = 1'b1;
                  state_nxt = RUN;
               end else begin
                  md_cnt_nxt = md_cnt - MD_W'(1);
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

   // Saturating count of cycles with the PC frozen
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stall_cnt_o <= '0;
      end else if (!pc_write_o && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a behavioural model queues expected
// outputs per cycle and they are compared against the DUT on the falling edge.
module tb_hazard_stall_ctrl;

   localparam int unsigned AW   = 6;
   localparam int unsigned MDC  = 8;
   localparam int unsigned CW   = 4;
   localparam int unsigned CMAX = 15;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] id_rs, id_rt, ex_rt;
   logic          uses_rt, muldiv, br, mem_rd;
   logic          pc_write, if_id_write, if_id_flush, bubble, hold, busy, done;
   logic [CW-1:0] stall_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string         tag;
      logic [6:0]    ctl;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   // model state
   int m_busy_left = 0;
   int m_cnt       = 0;

   hazard_stall_ctrl #(.REG_ADDR_W(AW), .MULDIV_CYCLES(MDC), .CNT_W(CW)) dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .id_rs_addr_i  (id_rs),
      .id_rt_addr_i  (id_rt),
      .id_uses_rt_i  (uses_rt),
      .id_muldiv_i   (muldiv),
      .branch_taken_i(br),
      .ex_mem_read_i (mem_rd),
      .ex_rt_addr_i  (ex_rt),
      .pc_write_o    (pc_write),
      .if_id_write_o (if_id_write),
      .if_id_flush_o (if_id_flush),
      .id_ex_bubble_o(bubble),
      .id_ex_hold_o  (hold),
      .ex_busy_o     (busy),
      .md_done_o     (done),
      .stall_cnt_o   (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   // Drive one cycle of stimulus (called just after a rising edge)
   task automatic step(input string tag, input logic r, input logic [AW-1:0] rs,
                       input logic [AW-1:0] rt, input logic urt, input logic md,
                       input logic b, input logic mr, input logic [AW-1:0] ert);
      exp_t e;
      logic hz;
      logic pw, iw, fl, bb, hd, bs, dn;
      rst_n = r; id_rs = rs; id_rt = rt; uses_rt = urt; muldiv = md;
      br = b; mem_rd = mr; ex_rt = ert;

      if (!r) begin
         m_busy_left = 0;
         m_cnt       = 0;
      end
      hz = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));
      {pw, iw, fl, bb, hd, bs, dn} = 7'b0;
      if (!r) begin
         bb = 1'b1;
      end else if (m_busy_left > 0) begin
         hd = 1'b1; bs = 1'b1; dn = (m_busy_left == 1);
      end else if (hz) begin
         bb = 1'b1;
      end else begin
         pw = 1'b1; iw = 1'b1; fl = b;
      end
      e.tag = tag;
      e.ctl = {pw, iw, fl, bb, hd, bs, dn};
      e.cnt = CW'(m_cnt);
      exp_q.push_back(e);

      @(negedge clk);
      e = exp_q.pop_front();
      check({e.tag, ".ctl"}, 32'({pc_write, if_id_write, if_id_flush, bubble, hold, busy, done}),
            32'(e.ctl));
      check({e.tag, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));

      @(posedge clk);
      if (r) begin
         if (!pw && m_cnt < CMAX) m_cnt++;
         if (m_busy_left > 0) m_busy_left--;
         else if (!hz && md) m_busy_left = MDC;
      end
      #1;
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b1, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0);
   endtask

   initial begin
      rst_n = 1'b0; id_rs = '0; id_rt = '0; uses_rt = 1'b0; muldiv = 1'b0;
      br = 1'b0; mem_rd = 1'b0; ex_rt = '0;
      @(posedge clk); #1;

      // reset held, then released
      for (int i = 0; i < 3; i++) step("reset", 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      idle("post_reset");

      // load-use variants
      step("lu_rs",      1'b1, 6'd5, 6'd3, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5);
      idle("lu_after");
      step("lu_rt",      1'b1, 6'd4, 6'd5, 1'b1, 1'b0, 1'b0, 1'b1, 6'd5);
      step("lu_r0",      1'b1, 6'd0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1, 6'd0);
      step("lu_rt_nouse",1'b1, 6'd4, 6'd5, 1'b0, 1'b0, 1'b0, 1'b1, 6'd5);
      step("lu_noload",  1'b1, 6'd5, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0, 6'd5);

      // branches
      step("br_taken",   1'b1, 6'd1, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
      idle("br_after");
      step("br_lu",      1'b1, 6'd7, 6'd2, 1'b0, 1'b0, 1'b1, 1'b1, 6'd7);
      step("md_lu",      1'b1, 6'd7, 6'd2, 1'b0, 1'b1, 1'b0, 1'b1, 6'd7);

      // mul/div occupancy
      step("md_start",   1'b1, 6'd1, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      for (int i = 0; i < MDC; i++) idle("md_busy");
      idle("md_back");

      // branch held across mul/div
      step("mdb_start",  1'b1, 6'd1, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      for (int i = 0; i < MDC + 1; i++)
         step("mdb_br",  1'b1, 6'd1, 6'd2, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
      idle("mdb_after");

      // reset on third busy cycle
      step("mdr_start",  1'b1, 6'd1, 6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
      idle("mdr_busy1");
      idle("mdr_busy2");
      step("mdr_reset",  1'b0, 6'd1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
      for (int i = 0; i < 3; i++) idle("mdr_after");

      // counter saturation
      for (int i = 0; i < 20; i++)
         step("sat_lu",  1'b1, 6'd9, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd9);
      check("sat_final", 32'(stall_cnt), 32'(CMAX));

      // random traffic
      for (int i = 0; i < 200; i++) begin
         logic b, m;
         b = 1'($urandom_range(0, 1));
         m = b ? 1'b0 : (($urandom_range(0, 7)) == 0);
         step("rand", ($urandom_range(0, 40) != 0),
              AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), m, b,
              1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
